inst_fill_engine: RTL and testbench
===================================

# inst_fill_engine

Instruction-cache line-fill engine that replaces the single-shot allocate stage. On a demand miss it issues one burst read, assembles `CACHE_LINE_SIZE/BURST_WIDTH` beats into a full line and writes it into the data/tag arrays. It then optionally issues up to `PREFETCH_DEPTH` sequential next-line prefetch fills. It sits between the icache control FSM (miss side) and the memory burst interface (fill side).

## Interface
- `CACHE_LINE_SIZE`, 256: line width in bits; must be a multiple of `BURST_WIDTH`.
- `BURST_WIDTH`, 64: memory data beat width; `BEATS = CACHE_LINE_SIZE/BURST_WIDTH`, must be ≥ 2.
- `PREFETCH_DEPTH`, 1: sequential next-line prefetches per demand miss, range 0..7.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `miss_req`  in  1  demand miss; sampled only when `miss_ready`=1.
- `miss_addr`  in  32  miss byte address; the low log2(`CACHE_LINE_SIZE`/8) bits are ignored.
- `miss_ready`  out  1  engine idle and accepting a miss.
- `flush`  in  1  redirect; cancels remaining and in-flight prefetches.
- `mem_read`  out  1  burst read request; held until accepted.
- `mem_addr`  out  32  line-aligned request address.
- `mem_ready`  in  1  request accepted when `mem_read & mem_ready`.
- `mem_rvalid`  in  1  read beat valid.
- `mem_rdata`  in  `BURST_WIDTH`  read beat data.
- `fill_we_n`  out  1  array write enable, active-low, one-cycle pulse.
- `fill_addr`  out  32  line-aligned address of the written line.
- `fill_line`  out  `CACHE_LINE_SIZE`  assembled line.
- `fill_is_prefetch`  out  1  current fill is a prefetch (for PLRU/insertion policy).

## Operation
- FSM states: IDLE, REQ, BEAT, WRITE.
- **IDLE**
  - `miss_ready`=1.
  - On `miss_req`: latch `line_addr = miss_addr & ~(LINE_BYTES-1)`, set `pf_left = PREFETCH_DEPTH`, clear `is_pf` and `drop`, go to REQ.
- **REQ**
  - `mem_read`=1 and `mem_addr`=`line_addr`.
  - On `mem_ready`: clear `beat_cnt`, go to BEAT.
- **BEAT**
  - Each `mem_rvalid` writes `mem_rdata` into line slice `[beat_cnt*BURST_WIDTH +: BURST_WIDTH]`, i.e. beat 0 fills the LSBs.
  - On the last beat (`beat_cnt==BEATS-1`), go to WRITE.
- **WRITE**
  - Drives `fill_we_n`=0 for exactly one cycle, unless `drop`=1.
  - Next state:
    - If `pf_left>0` and no flush has been seen: `line_addr += LINE_BYTES` (modulo 2^32, wraps to 0), `pf_left--`, `is_pf`=1, go to REQ.
    - Otherwise go to IDLE.
- **Flush**
  - Clears `pf_left` in any state.
  - Demand fill: in-flight fill still completes and is written.
  - Prefetch in REQ (not yet accepted): go to IDLE immediately with no request issued.
  - Prefetch in BEAT: set `drop`=1. The remaining beats are drained, `fill_we_n` stays 1, then go to IDLE.
- Arbitration and input masking:
  - `flush` wins over a simultaneous `miss_req` in IDLE; the miss is not accepted that cycle.
  - `mem_rvalid` outside BEAT is ignored.
  - `miss_req` outside IDLE is ignored; the controller must hold it.

## Timing
- Reset values:
  - FSM state IDLE.
  - Outputs: `miss_ready`=1, `mem_read`=0, `mem_addr`=0, `fill_we_n`=1, `fill_addr`=0, `fill_line`=0, `fill_is_prefetch`=0.
  - Counters cleared.
- Reset mid-operation: returns to IDLE in one cycle and drops any partial line. The memory side must also be reset.
- `miss_req` accepted at cycle T: `mem_read`=1 from T+1.
- Last beat at cycle B: `fill_we_n`=0 in B+1, with `fill_addr`, `fill_line` and `fill_is_prefetch` valid that same cycle.
  - `fill_line` holds its value until the next fill.
- Prefetch `mem_read` is asserted at B+2.
- Demand miss best case (`mem_ready` same cycle, back-to-back beats): write at T+1+BEATS+1.
- `miss_ready` returns to 1 in the cycle after the final WRITE.
- All outputs are registered or decoded from state only; no combinational path from `mem_*` inputs to outputs.

## Configuration
- `INST_FILL_PREFETCH_EN` defined:
  - Prefetch logic, `pf_left` counter and `drop` path are compiled in; behaviour is as described above.
- Not defined:
  - `PREFETCH_DEPTH` is ignored (treated as 0).
  - `fill_is_prefetch` is tied to 0 and `flush` only blocks miss acceptance in IDLE.
  - Every fill returns to IDLE after WRITE.

## Test plan
- Reset, then idle 5 cycles -> `miss_ready`=1, `mem_read`=0, `fill_we_n`=1 throughout.
- DEPTH=0, miss 0x0000_1234, `mem_ready` immediate, 4 beats 0x11..,0x22..,0x33..,0x44.. -> `mem_addr`=0x0000_1220, single `fill_we_n` pulse 1 cycle after beat 4, line = {beat3,beat2,beat1,beat0}.
- DEPTH=2, miss 0x100 -> demand fill 0x100, then prefetch fills 0x120 and 0x140 with `fill_is_prefetch`=1, then `miss_ready`=1.
- DEPTH=2, miss 0xFFFF_FFE0 -> prefetch addresses wrap to 0x0000_0000 and 0x0000_0020.
- DEPTH=1, flush during 2nd beat of the prefetch -> remaining beats drained, no `fill_we_n` pulse, IDLE afterwards; flush during demand BEAT -> demand line written, no prefetch issued.
- `mem_ready` held low 7 cycles in REQ -> `mem_read` and `mem_addr` stable all 7 cycles; stray `mem_rvalid` in REQ ignored (line unchanged).

Source files
------------

// File: rtl/inst_fill_engine_if.sv
// Miss-side, memory-burst and array-fill signals of the instruction-cache line-fill engine.
// The master modport is the engine; the slave modport is the icache controller plus memory.
interface inst_fill_engine_if #(
    parameter int unsigned CACHE_LINE_SIZE = 256,
    parameter int unsigned BURST_WIDTH     = 64
);
    logic                       miss_req;
    logic [31:0]                miss_addr;
    logic                       miss_ready;
    logic                       flush;

    logic                       mem_read;
    logic [31:0]                mem_addr;
    logic                       mem_ready;
    logic                       mem_rvalid;
    logic [BURST_WIDTH-1:0]     mem_rdata;

    logic                       fill_we_n;
    logic [31:0]                fill_addr;
    logic [CACHE_LINE_SIZE-1:0] fill_line;
    logic                       fill_is_prefetch;

    modport master (
        input  miss_req, miss_addr, flush, mem_ready, mem_rvalid, mem_rdata,
        output miss_ready, mem_read, mem_addr, fill_we_n, fill_addr, fill_line, fill_is_prefetch
    );

    modport slave (
        output miss_req, miss_addr, flush, mem_ready, mem_rvalid, mem_rdata,
        input  miss_ready, mem_read, mem_addr, fill_we_n, fill_addr, fill_line, fill_is_prefetch
    );
endinterface

// File: rtl/inst_fill_engine.sv
// Instruction-cache line-fill engine: one burst per demand miss, then optional next-line prefetches.
// Prefetch support is compiled in only when INST_FILL_PREFETCH_EN is defined.
module inst_fill_engine #(
    parameter int unsigned CACHE_LINE_SIZE = 256,
    parameter int unsigned BURST_WIDTH     = 64,
    parameter int unsigned PREFETCH_DEPTH  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    inst_fill_engine_if.master     bus
);
    localparam int unsigned BEATS      = CACHE_LINE_SIZE / BURST_WIDTH;
    localparam int unsigned LINE_BYTES = CACHE_LINE_SIZE / 8;
    localparam int unsigned CNT_W      = (BEATS > 2) ? $clog2(BEATS) : 1;
    localparam logic [31:0] LINE_MASK  = 32'(LINE_BYTES - 1);
    localparam logic [31:0] LINE_STEP  = 32'(LINE_BYTES);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (PREFETCH_DEPTH > 7 || BEATS < 2 || (CACHE_LINE_SIZE % BURST_WIDTH) != 0) begin : g_bad_cfg
        $error("inst_fill_engine: unsupported parameter combination");
    end

    typedef enum logic [1:0] {IDLE, REQ, BEAT, WRITE} state_e;

    state_e                     state_q, state_d;
    logic [31:0]                line_addr_q, line_addr_d;
    logic [CNT_W-1:0]           beat_cnt_q, beat_cnt_d;
    logic [CACHE_LINE_SIZE-1:0] line_buf_q, line_buf_d;

    logic                       miss_ready_q, miss_ready_d;
    logic                       mem_read_q, mem_read_d;
    logic [31:0]                mem_addr_q, mem_addr_d;
    logic                       fill_we_n_q, fill_we_n_d;
    logic [31:0]                fill_addr_q, fill_addr_d;
    logic [CACHE_LINE_SIZE-1:0] fill_line_q, fill_line_d;
    logic                       fill_commit;

`ifdef INST_FILL_PREFETCH_EN
    localparam logic [2:0] PF_INIT = 3'(PREFETCH_DEPTH);

    logic [2:0] pf_left_q, pf_left_d;
    logic       is_pf_q, is_pf_d;
    logic       drop_q, drop_d;
    logic       fill_is_prefetch_q, fill_is_prefetch_d;
`endif

    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        beat_cnt_d  = beat_cnt_q;
        line_buf_d  = line_buf_q;
`ifdef INST_FILL_PREFETCH_EN
        pf_left_d   = bus.flush ? 3'd0 : pf_left_q;
        is_pf_d     = is_pf_q;
        drop_d      = drop_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.miss_req && !bus.flush) begin
                    line_addr_d = bus.miss_addr & ~LINE_MASK;
                    state_d     = REQ;
`ifdef INST_FILL_PREFETCH_EN
                    pf_left_d   = PF_INIT;
                    is_pf_d     = 1'b0;
                    drop_d      = 1'b0;
`endif
                end
            end
            REQ: begin
                if (bus.mem_ready) begin
                    beat_cnt_d = '0;
                    state_d    = BEAT;
                end
`ifdef INST_FILL_PREFETCH_EN
                // A flushed prefetch accepted in the same cycle still gets its beats, so drain them.
                if (is_pf_q && bus.flush) begin
                    if (bus.mem_ready) drop_d  = 1'b1;
                    else               state_d = IDLE;
                end
`endif
            end
            BEAT: begin
                if (bus.mem_rvalid) begin
                    line_buf_d[32'(beat_cnt_q) * BURST_WIDTH +: BURST_WIDTH] = bus.mem_rdata;
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == LAST_BEAT) state_d = WRITE;
                end
`ifdef INST_FILL_PREFETCH_EN
                if (is_pf_q && bus.flush) drop_d = 1'b1;
`endif
            end
            WRITE: begin
                state_d = IDLE;
`ifdef INST_FILL_PREFETCH_EN
                if (pf_left_q != 3'd0 && !bus.flush) begin
                    line_addr_d = line_addr_q + LINE_STEP;
                    pf_left_d   = pf_left_q - 3'd1;
                    is_pf_d     = 1'b1;
                    drop_d      = 1'b0;
                    state_d     = REQ;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered off the next state so they carry no path from mem_* inputs.
`ifdef INST_FILL_PREFETCH_EN
        fill_commit = (state_d == WRITE) && !drop_d;
`else
        fill_commit = (state_d == WRITE);
`endif
        miss_ready_d = (state_d == IDLE);
        mem_read_d   = (state_d == REQ);
        mem_addr_d   = (state_d == REQ) ? line_addr_d : mem_addr_q;
        fill_we_n_d  = !fill_commit;
        fill_addr_d  = fill_commit ? line_addr_q : fill_addr_q;
        fill_line_d  = fill_commit ? line_buf_d  : fill_line_q;
`ifdef INST_FILL_PREFETCH_EN
        fill_is_prefetch_d = fill_commit ? is_pf_q : fill_is_prefetch_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            line_addr_q  <= '0;
            beat_cnt_q   <= '0;
            line_buf_q   <= '0;
            miss_ready_q <= 1'b1;
            mem_read_q   <= 1'b0;
            mem_addr_q   <= '0;
            fill_we_n_q  <= 1'b1;
            fill_addr_q  <= '0;
            fill_line_q  <= '0;
`ifdef INST_FILL_PREFETCH_EN
            pf_left_q          <= '0;
            is_pf_q            <= 1'b0;
            drop_q             <= 1'b0;
            fill_is_prefetch_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            line_addr_q  <= line_addr_d;
            beat_cnt_q   <= beat_cnt_d;
            line_buf_q   <= line_buf_d;
            miss_ready_q <= miss_ready_d;
            mem_read_q   <= mem_read_d;
            mem_addr_q   <= mem_addr_d;
            fill_we_n_q  <= fill_we_n_d;
            fill_addr_q  <= fill_addr_d;
            fill_line_q  <= fill_line_d;
`ifdef INST_FILL_PREFETCH_EN
            pf_left_q          <= pf_left_d;
            is_pf_q            <= is_pf_d;
            drop_q             <= drop_d;
            fill_is_prefetch_q <= fill_is_prefetch_d;
`endif
        end
    end

    assign bus.miss_ready = miss_ready_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.fill_we_n  = fill_we_n_q;
    assign bus.fill_addr  = fill_addr_q;
    assign bus.fill_line  = fill_line_q;
`ifdef INST_FILL_PREFETCH_EN
    assign bus.fill_is_prefetch = fill_is_prefetch_q;
`else
    assign bus.fill_is_prefetch = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fill_engine.sv
// Scoreboard bench for inst_fill_engine: directed misses push expected requests and fills,
// a negedge monitor pops and compares them as the engine presents them.
module tb_inst_fill_engine;
    localparam int unsigned DEPTH = 2;
`ifdef INST_FILL_PREFETCH_EN
    localparam int EFF_DEPTH = DEPTH;
    localparam bit PF_EN     = 1'b1;
`else
    localparam int EFF_DEPTH = 0;
    localparam bit PF_EN     = 1'b0;
`endif
    localparam logic [255:0] LINE_A =
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] line;
        logic         pf;
    } fill_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] exp_req[$];
    fill_t       exp_fill[$];

    inst_fill_engine_if #(.CACHE_LINE_SIZE(256), .BURST_WIDTH(64)) bus ();

    inst_fill_engine #(
        .CACHE_LINE_SIZE(256),
        .BURST_WIDTH    (64),
        .PREFETCH_DEPTH (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        for (int b = 0; b < 4; b++) l[b*64 +: 64] = {a, 24'hC0FFEE, 8'(b)};
        return l;
    endfunction

    // Monitor: compares every accepted request and every array write against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_read === 1'b1 && bus.mem_ready === 1'b1) begin
                if (exp_req.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL req_unexpected: got request %h, want none", bus.mem_addr);
                end else begin
                    check("req_addr", bus.mem_addr, exp_req.pop_front());
                end
            end
            if (bus.fill_we_n === 1'b0) begin
                if (exp_fill.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL fill_unexpected: got write to %h, want none", bus.fill_addr);
                end else begin
                    fill_t e;
                    e = exp_fill.pop_front();
                    check("fill_addr", bus.fill_addr, e.addr);
                    check("fill_line", bus.fill_line, e.line);
                    check("fill_is_prefetch", bus.fill_is_prefetch, e.pf);
                end
            end
        end
    end

    task automatic issue_miss(input logic [31:0] a);
        check("miss_ready_before", bus.miss_ready, 1'b1);
        bus.miss_addr = a;
        bus.miss_req  = 1'b1;
        step();
        bus.miss_req  = 1'b0;
        check("mem_read_at_T1", bus.mem_read, 1'b1);
    endtask

    // Memory side of one burst: optional REQ stall (with a stray beat), then four beats.
    task automatic serve(input logic [31:0] addr, input logic [255:0] line,
                         input int ready_delay, input int flush_beat, input bit exp_write);
        int waited = 0;
        while (bus.mem_read !== 1'b1 && waited < 40) begin
            step();
            waited++;
        end
        if (bus.mem_read !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL req_timeout: got mem_read=%b, want 1 for %h", bus.mem_read, addr);
            return;
        end
        for (int d = 0; d < ready_delay; d++) begin
            check("req_hold_read", bus.mem_read, 1'b1);
            check("req_hold_addr", bus.mem_addr, addr);
            bus.mem_rvalid = (d == 2);
            bus.mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
            step();
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_ready  = 1'b1;
        step();
        bus.mem_ready  = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = line[b*64 +: 64];
            bus.flush      = (b == flush_beat);
            step();
        end
        bus.mem_rvalid = 1'b0;
        bus.flush      = 1'b0;
        check("we_after_last_beat", bus.fill_we_n, !exp_write);
        step();
        check("we_single_cycle", bus.fill_we_n, 1'b1);
    endtask

    // One demand miss plus its prefetches; flush_fill selects which fill (0 = demand) sees flush.
    task automatic run_seq(input logic [31:0] miss, input logic [255:0] dline, input int delay,
                           input int flush_fill, input int flush_beat);
        logic [31:0]  a;
        logic [255:0] l;
        int           n_fills;
        bit           wr;
        bit           more;
        a = miss & 32'hFFFF_FFE0;
        n_fills = 1 + EFF_DEPTH;
        if (flush_fill >= 0 && flush_fill + 1 < n_fills) n_fills = flush_fill + 1;
        for (int i = 0; i < n_fills; i++) begin
            l  = (i == 0) ? dline : line_of(a);
            wr = !(i > 0 && i == flush_fill);
            exp_req.push_back(a);
            if (wr) exp_fill.push_back('{a, l, (i > 0)});
            if (i == 0) issue_miss(miss);
            serve(a, l, (i == 0) ? delay : 0, (i == flush_fill) ? flush_beat : -1, wr);
            more = (i + 1 < n_fills);
            check("next_req_at_B2", bus.mem_read, more);
            check("miss_ready_after", bus.miss_ready, !more);
            a = a + 32'd32;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.miss_req   = 1'b0;
        bus.miss_addr  = '0;
        bus.flush      = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        repeat (3) step();
        rst = 1'b0;

        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_fill_addr", bus.fill_addr, 32'h0);
        check("rst_fill_line", bus.fill_line, 256'h0);
        check("rst_fill_is_prefetch", bus.fill_is_prefetch, 1'b0);
        for (int c = 0; c < 5; c++) begin
            check("idle_miss_ready", bus.miss_ready, 1'b1);
            check("idle_mem_read", bus.mem_read, 1'b0);
            check("idle_fill_we_n", bus.fill_we_n, 1'b1);
            step();
        end

        run_seq(32'h0000_1234, LINE_A, 0, -1, -1);
        check("a_line_beat_order", bus.fill_line,
              PF_EN ? line_of(32'h0000_1260) : LINE_A);
        repeat (2) step();

        run_seq(32'h0000_0100, line_of(32'h0000_0100), 7, -1, -1);
        repeat (2) step();

        run_seq(32'hFFFF_FFE0, line_of(32'hFFFF_FFE0), 0, -1, -1);
        check("wrap_last_fill_addr", bus.fill_addr, PF_EN ? 32'h0000_0020 : 32'hFFFF_FFE0);
        repeat (2) step();

        run_seq(32'h0000_2010, line_of(32'h0000_2000), 0, 1, 1);
        check("pf_drop_keeps_line", bus.fill_line, line_of(32'h0000_2000));
        repeat (2) step();

        run_seq(32'h0000_3008, line_of(32'h0000_3000), 0, 0, 1);
        repeat (2) step();

        bus.miss_addr = 32'h0000_5000;
        bus.miss_req  = 1'b1;
        bus.flush     = 1'b1;
        step();
        bus.miss_req  = 1'b0;
        bus.flush     = 1'b0;
        check("flush_blocks_miss_read", bus.mem_read, 1'b0);
        check("flush_blocks_miss_ready", bus.miss_ready, 1'b1);
        repeat (2) step();

        exp_req.push_back(32'h0000_4000);
        issue_miss(32'h0000_4000);
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 64'h5555_5555_5555_5555;
        repeat (2) step();
        bus.mem_rvalid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_miss_ready", bus.miss_ready, 1'b1);
        check("midrst_mem_read", bus.mem_read, 1'b0);
        check("midrst_fill_line", bus.fill_line, 256'h0);
        check("midrst_fill_we_n", bus.fill_we_n, 1'b1);
        repeat (6) step();
        check("midrst_still_idle", bus.mem_read, 1'b0);

        check("fill_queue_empty", exp_fill.size(), 0);
        check("req_queue_empty", exp_req.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
